input_port_ctrl_mh: RTL and testbench

- Next-generation input-port controller for the packet-connected circuit-switched router; one instance per input link.
- Accepts a path-setup header and issues per-hop route requests to the arbiter.
- Tracks grant/deny/pack/suspend/cancel and locks the circuit.
- Generalises the previous input FSM:
  - parametrised number of source-route segments;
  - bounded deny-retry with backoff;
  - request timeout;
  - explicit status outputs.

---
 rtl/router_pkg.sv | 28 ++
 rtl/route_seg_sel.sv | 38 +++
 rtl/input_port_ctrl_mh.sv | 199 +++++++++++++++++++
 tb/tb_input_port_ctrl_mh.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router input-port controller: FSM states,
// backward-control bit positions, header flag offsets and segment helper.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BACKOFF,
    ST_PRELOCK,
    ST_LOCK,
    ST_FAIL
  } state_t;

  localparam int BW_PACK    = 0;
  localparam int BW_SUSPEND = 1;
  localparam int BW_CANCEL  = 2;

  // Header flags are addressed as offsets from the flit MSB: bit DATAW-ofs.
  localparam int HDR_SETUP_OFS = 1;
  localparam int HDR_PROBE_OFS = 2;
  localparam int HDR_MODE_OFS  = 3;

  // Segment k sits one segment above the flit LSB slot.
  function automatic int unsigned seg_lsb(input int unsigned k, input int unsigned addrw);
    return (k + 1) * addrw;
  endfunction

endpackage

// File: rtl/route_seg_sel.sv
// Selects the current and following route segment from the header flit and
// decides whether a packed hop should continue to the next segment.
module route_seg_sel
  import router_pkg::*;
#(
  parameter int DATAW = 66,
  parameter int ADDRW = 8,
  parameter int NSEG  = 4,
  parameter int SEGW  = 2,
  parameter logic [ADDRW/2-1:0] LOCAL_X = '0,
  parameter logic [ADDRW/2-1:0] LOCAL_Y = '0
) (
  input  logic [DATAW-1:0] i_data,
  input  logic [SEGW-1:0]  i_seg_idx,
  output logic [ADDRW-1:0] o_seg_cur,
  output logic [ADDRW-1:0] o_seg_nxt,
  output logic             o_cont
);

  localparam logic [ADDRW-1:0] LOCAL_ADDR = {LOCAL_Y, LOCAL_X};

  logic w_setup;
  logic w_probe;
  logic w_mode;

  assign w_setup = i_data[DATAW-HDR_SETUP_OFS];
  assign w_probe = i_data[DATAW-HDR_PROBE_OFS];
  assign w_mode  = i_data[DATAW-HDR_MODE_OFS];

  assign o_seg_cur = ADDRW'(i_data >> seg_lsb(32'(i_seg_idx), ADDRW));
  assign o_seg_nxt = ADDRW'(i_data >> seg_lsb(32'(i_seg_idx) + 32'd1, ADDRW));

  // Multicast headers only ever use segment 0, so they never advance.
  assign o_cont = !w_mode && !w_probe && w_setup &&
                  (o_seg_cur == LOCAL_ADDR) && (o_seg_nxt != '0) &&
                  (32'(i_seg_idx) < NSEG - 1);

endmodule

// File: rtl/input_port_ctrl_mh.sv
// Input-port controller: walks the source route hop by hop, retries denied
// requests with backoff, times out silent arbiters and locks the circuit.
module input_port_ctrl_mh
  import router_pkg::*;
#(
  parameter int DATAW       = 66,
  parameter int ADDRW       = 8,
  parameter int NSEG        = 4,
  parameter logic [ADDRW/2-1:0] LOCAL_X = 4'd2,
  parameter logic [ADDRW/2-1:0] LOCAL_Y = 4'd2,
  parameter int BWCTRLW     = 3,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 4,
  parameter int REQ_TIMEOUT = 64,
  localparam int SEGW       = (NSEG > 1) ? $clog2(NSEG) : 1,
  localparam int RETW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stb_i,
  input  logic               fwd_i,
  input  logic [DATAW-1:0]   data_i,
  input  logic               grant_i,
  input  logic               deny_i,
  input  logic [BWCTRLW-1:0] bwctrl_i,
  output logic               stb_o,
  output logic               fwd_o,
  output logic [DATAW-1:0]   data_o,
  output logic               request_o,
  output logic [ADDRW-1:0]   address_o,
  output logic [SEGW-1:0]    seg_idx_o,
  output logic               pack_o,
  output logic               suspend_o,
  output logic               cancel_o,
  output logic               fail_o,
  output logic               timeout_o,
  output logic               locked_o,
  output logic [RETW-1:0]    retry_cnt_o
);

  localparam int TMR_MAX = (REQ_TIMEOUT > BACKOFF_CYC) ? REQ_TIMEOUT : BACKOFF_CYC;
  localparam int TMRW    = $clog2(TMR_MAX + 1);

  state_t             r_state;
  logic [SEGW-1:0]    r_seg_idx;
  logic [RETW-1:0]    r_retry;
  logic [TMRW-1:0]    r_timer;
  logic               r_request;
  logic [ADDRW-1:0]   r_address;
  logic               r_fail;
  logic               r_timeout;
  logic [BWCTRLW-1:0] r_bwctrl;

  state_t             w_next_state;
  logic [SEGW-1:0]    w_next_seg;
  logic [RETW-1:0]    w_next_retry;
  logic               w_tmo_fail;
  logic [ADDRW-1:0]   w_seg_cur;
  logic [ADDRW-1:0]   w_seg_nxt;
  logic [ADDRW-1:0]   w_sel_seg;
  logic [ADDRW-1:0]   w_next_addr;
  logic               w_cont;

  route_seg_sel #(
    .DATAW   (DATAW),
    .ADDRW   (ADDRW),
    .NSEG    (NSEG),
    .SEGW    (SEGW),
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y)
  ) u_seg_sel (
    .i_data    (data_i),
    .i_seg_idx (r_seg_idx),
    .o_seg_cur (w_seg_cur),
    .o_seg_nxt (w_seg_nxt),
    .o_cont    (w_cont)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    w_next_seg   = r_seg_idx;
    w_next_retry = r_retry;
    w_tmo_fail   = 1'b0;
    if (!stb_i) begin
      w_next_state = ST_IDLE;
      w_next_seg   = '0;
      w_next_retry = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_i[DATAW-HDR_SETUP_OFS]) begin
            w_next_state = ST_REQ;
            w_next_seg   = '0;
            w_next_retry = '0;
          end
        end
        ST_REQ: begin
          if (deny_i) begin
            if (r_retry < RETW'(MAX_RETRY)) begin
              w_next_state = ST_BACKOFF;
              w_next_retry = r_retry + 1'b1;
            end else begin
              w_next_state = ST_FAIL;
            end
          end else if (grant_i) begin
            w_next_state = ST_PRELOCK;
          end else if (r_timer == TMRW'(REQ_TIMEOUT - 1)) begin
            w_next_state = ST_FAIL;
            w_tmo_fail   = 1'b1;
          end
        end
        ST_BACKOFF: begin
          if (r_timer == TMRW'(BACKOFF_CYC - 1)) w_next_state = ST_REQ;
        end
        ST_PRELOCK: begin
          if (deny_i) begin
            w_next_state = ST_FAIL;
          end else if (bwctrl_i[BW_PACK]) begin
            // w_cont already requires seg_idx < NSEG-1, so the increment cannot wrap.
            if (w_cont) begin
              w_next_state = ST_REQ;
              w_next_seg   = r_seg_idx + 1'b1;
              w_next_retry = '0;
            end else begin
              w_next_state = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (deny_i) begin
            w_next_state = ST_FAIL;
          end else if (bwctrl_i[BW_CANCEL]) begin
            w_next_state = ST_IDLE;
            w_next_seg   = '0;
            w_next_retry = '0;
          end
        end
        ST_FAIL: w_next_state = ST_FAIL;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sel_seg   = (w_next_seg == r_seg_idx) ? w_seg_cur : w_seg_nxt;
    w_next_addr = '0;
    if (w_next_state == ST_REQ) begin
      w_next_addr = data_i[DATAW-HDR_MODE_OFS]
                  ? {w_sel_seg[ADDRW-1 -: ADDRW/2], {(ADDRW/2){1'b0}}}
                  : w_sel_seg;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state here is flops, so everything is cleared.
    if (reset) begin
      r_state   <= ST_IDLE;
      r_seg_idx <= '0;
      r_retry   <= '0;
      r_timer   <= '0;
      r_request <= 1'b0;
      r_address <= '0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_bwctrl  <= '0;
    end else begin
      r_state   <= w_next_state;
      r_seg_idx <= w_next_seg;
      r_retry   <= w_next_retry;
      // One timer serves both REQ timeout and BACKOFF length; it restarts on every state change.
      if (!stb_i || (w_next_state != r_state) || !(r_state inside {ST_REQ, ST_BACKOFF}))
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
      r_request <= (w_next_state == ST_REQ);
      r_address <= w_next_addr;
      r_fail    <= (w_next_state == ST_FAIL) && (r_state != ST_FAIL);
      r_timeout <= w_tmo_fail;
      r_bwctrl  <= bwctrl_i;
    end
  end

  assign stb_o       = stb_i;
  assign fwd_o       = fwd_i;
  assign data_o      = data_i;
  assign request_o   = r_request;
  assign address_o   = r_address;
  assign seg_idx_o   = r_seg_idx;
  assign pack_o      = r_bwctrl[BW_PACK];
  assign suspend_o   = r_bwctrl[BW_SUSPEND];
  assign cancel_o    = r_bwctrl[BW_CANCEL];
  assign fail_o      = r_fail;
  assign timeout_o   = r_timeout;
  assign locked_o    = (r_state == ST_LOCK);
  assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_input_port_ctrl_mh.sv
// Randomized bench for input_port_ctrl_mh, compared every cycle against a
// behavioural path-setup model that counts dwell time per phase.
module tb_input_port_ctrl_mh;

  localparam int DATAW       = 66;
  localparam int ADDRW       = 8;
  localparam int NSEG        = 4;
  localparam int MAX_RETRY   = 3;
  localparam int BACKOFF_CYC = 4;
  localparam int REQ_TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             stb_i;
  logic             fwd_i;
  logic [DATAW-1:0] data_i;
  logic             grant_i;
  logic             deny_i;
  logic [2:0]       bwctrl_i;
  logic             stb_o;
  logic             fwd_o;
  logic [DATAW-1:0] data_o;
  logic             request_o;
  logic [ADDRW-1:0] address_o;
  logic [1:0]       seg_idx_o;
  logic             pack_o;
  logic             suspend_o;
  logic             cancel_o;
  logic             fail_o;
  logic             timeout_o;
  logic             locked_o;
  logic [1:0]       retry_cnt_o;

  always #5 clk = ~clk;

  input_port_ctrl_mh dut (
    .clk         (clk),
    .reset       (reset),
    .stb_i       (stb_i),
    .fwd_i       (fwd_i),
    .data_i      (data_i),
    .grant_i     (grant_i),
    .deny_i      (deny_i),
    .bwctrl_i    (bwctrl_i),
    .stb_o       (stb_o),
    .fwd_o       (fwd_o),
    .data_o      (data_o),
    .request_o   (request_o),
    .address_o   (address_o),
    .seg_idx_o   (seg_idx_o),
    .pack_o      (pack_o),
    .suspend_o   (suspend_o),
    .cancel_o    (cancel_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .locked_o    (locked_o),
    .retry_cnt_o (retry_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_REQ, M_BACKOFF, M_PRELOCK, M_LOCK, M_FAIL} mphase_e;

  mphase_e    m_ph;
  int         m_seg, m_retry, m_dwell;
  bit         m_req, m_fail, m_tmo;
  logic [7:0] m_addr;
  logic [2:0] m_bw;

  function automatic logic [7:0] seg_of(input logic [DATAW-1:0] d, input int k);
    return 8'(d >> ((k + 1) * ADDRW));
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_seg = 0; m_retry = 0; m_dwell = 1;
    m_req = 0; m_fail = 0; m_tmo = 0; m_addr = '0; m_bw = '0;
  endtask

  task automatic model_step(input bit stb, input logic [DATAW-1:0] d, input bit g,
                            input bit dn, input logic [2:0] bw);
    mphase_e    nph = m_ph;
    int         nseg = m_seg;
    int         nret = m_retry;
    bit         tmo = 0;
    bit         setup = d[DATAW-1];
    bit         probe = d[DATAW-2];
    bit         mode = d[DATAW-3];
    bit         cont;
    logic [7:0] s;
    cont = !mode && !probe && setup && (seg_of(d, m_seg) == 8'h22) &&
           (seg_of(d, m_seg + 1) != 8'h00) && (m_seg < NSEG - 1);
    if (!stb) begin
      nph = M_IDLE; nseg = 0; nret = 0;
    end else begin
      case (m_ph)
        M_IDLE:    if (setup) begin nph = M_REQ; nseg = 0; nret = 0; end
        M_REQ: begin
          if (dn) begin
            if (m_retry < MAX_RETRY) begin nph = M_BACKOFF; nret = m_retry + 1; end
            else nph = M_FAIL;
          end else if (g) nph = M_PRELOCK;
          else if (m_dwell == REQ_TIMEOUT) begin nph = M_FAIL; tmo = 1; end
        end
        M_BACKOFF: if (m_dwell == BACKOFF_CYC) nph = M_REQ;
        M_PRELOCK: begin
          if (dn) nph = M_FAIL;
          else if (bw[0]) begin
            if (cont) begin nph = M_REQ; nseg = m_seg + 1; nret = 0; end
            else nph = M_LOCK;
          end
        end
        M_LOCK: begin
          if (dn) nph = M_FAIL;
          else if (bw[2]) begin nph = M_IDLE; nseg = 0; nret = 0; end
        end
        default: ;
      endcase
    end
    m_fail  = (nph == M_FAIL) && (m_ph != M_FAIL);
    m_tmo   = tmo;
    m_req   = (nph == M_REQ);
    s       = seg_of(d, nseg);
    m_addr  = !m_req ? 8'h00 : (mode ? {s[7:4], 4'h0} : s);
    m_bw    = bw;
    m_dwell = (nph == m_ph) ? m_dwell + 1 : 1;
    m_ph    = nph;
    m_seg   = nseg;
    m_retry = nret;
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [DATAW-1:0] make_header();
    logic [DATAW-1:0] d;
    int kind;
    kind = $urandom_range(6);
    d = 66'({$urandom(), $urandom(), $urandom()});
    d[DATAW-1] = 1'b1;
    d[DATAW-2] = 1'b0;
    d[DATAW-3] = 1'b0;
    case (kind)
      0: begin d[15:8] = 8'h22; d[23:16] = 8'h23; end
      1: begin d[15:8] = 8'h22; d[23:16] = 8'h22; d[31:24] = 8'h22; d[39:32] = 8'h22; end
      2: begin d[15:8] = 8'h22; d[23:16] = 8'h22; d[31:24] = 8'h00; end
      3: ;
      4: begin d[DATAW-2] = 1'b1; d[15:8] = 8'h22; d[23:16] = 8'h23; end
      5: begin d[DATAW-3] = 1'b1; d[15:12] = 4'h5; end
      default: d[DATAW-1] = 1'b0;
    endcase
    return d;
  endfunction

  task automatic apply_cycle();
    #1;
    check("passthru", {stb_o, fwd_o, data_o}, {stb_i, fwd_i, data_i});
    @(posedge clk);
    if (reset) model_reset();
    else model_step(stb_i, data_i, grant_i, deny_i, bwctrl_i);
    #1;
    check("request",  request_o,   m_req);
    check("address",  address_o,   m_addr);
    check("seg_idx",  seg_idx_o,   m_seg);
    check("retry",    retry_cnt_o, m_retry);
    check("fail",     fail_o,      m_fail);
    check("timeout",  timeout_o,   m_tmo);
    check("locked",   locked_o,    m_ph == M_LOCK);
    check("bwctrl",   {cancel_o, suspend_o, pack_o}, m_bw);
    @(negedge clk);
  endtask

  task automatic run_phase(input int cycles, input int p_grant, input int p_deny,
                           input int p_pack, input int p_cancel, input int p_drop);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(99) < 3) data_i = make_header();
      stb_i    = ($urandom_range(999) >= p_drop);
      fwd_i    = 1'($urandom_range(1));
      grant_i  = ($urandom_range(99) < p_grant);
      deny_i   = ($urandom_range(99) < p_deny);
      bwctrl_i = {($urandom_range(99) < p_cancel), ($urandom_range(99) < 20),
                  ($urandom_range(99) < p_pack)};
      apply_cycle();
    end
  endtask

  initial begin
    reset = 1'b1; stb_i = 1'b1; fwd_i = 1'b0; grant_i = 1'b1; deny_i = 1'b0;
    bwctrl_i = 3'b111; data_i = make_header();
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) apply_cycle();
    reset = 1'b0;

    run_phase(800, 0, 0, 30, 2, 8);     // silent arbiter: timeouts
    run_phase(800, 5, 25, 30, 2, 8);    // deny-heavy: retries and backoff
    run_phase(800, 35, 2, 45, 4, 8);    // grant/pack-heavy: multi-hop and lock
    run_phase(600, 40, 40, 40, 5, 10);  // frequent simultaneous grant+deny
    run_phase(800, 12, 8, 30, 5, 15);   // mixed traffic with link drops

    reset = 1'b1;
    for (int i = 0; i < 2; i++) apply_cycle();
    reset = 1'b0;
    run_phase(400, 20, 10, 30, 5, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
